// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters, the issue-stage scoreboard
// lookups and the register-file write port.
interface regfile_wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_index;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_index;
    logic [31:0] lsu_data;
    logic        mark_en;
    logic [4:0]  mark_index;
    logic [4:0]  chk_index1;
    logic [4:0]  chk_index2;
    logic        chk_busy1;
    logic        chk_busy2;
    logic        wr_en;
    logic [4:0]  wr_index;
    logic [31:0] wr_data;
    logic [31:0] pending;

    modport slave (
        input  alu_valid, alu_index, alu_data,
        input  lsu_valid, lsu_index, lsu_data,
        input  mark_en, mark_index, chk_index1, chk_index2,
        output alu_ready, lsu_ready, chk_busy1, chk_busy2,
        output wr_en, wr_index, wr_data, pending
    );

    modport master (
        output alu_valid, alu_index, alu_data,
        output lsu_valid, lsu_index, lsu_data,
        output mark_en, mark_index, chk_index1, chk_index2,
        input  alu_ready, lsu_ready, chk_busy1, chk_busy2,
        input  wr_en, wr_index, wr_data, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: LSU-priority with an ALU starvation bound,
// a registered write port and a pending-write scoreboard for RAW stalls.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_index_q, wr_index_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] pending_q, pending_d;

    logic        alu_grant, lsu_grant, xfer;
    logic [4:0]  sel_index;
    logic [31:0] sel_data;

    // Handshake: a requester transfers when valid && ready in the same cycle;
    // ready depends only on valid and wait_cnt, and a refused requester holds
    // valid/index/data stable until granted.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!reset) begin
            if (bus.alu_valid && (wait_cnt_q == WAIT_LIMIT)) begin
                alu_grant = 1'b1;
            end else if (bus.lsu_valid) begin
                lsu_grant = 1'b1;
            end else if (bus.alu_valid) begin
                alu_grant = 1'b1;
            end
        end
    end

    assign xfer      = alu_grant | lsu_grant;
    assign sel_index = alu_grant ? bus.alu_index : bus.lsu_index;
    assign sel_data  = alu_grant ? bus.alu_data  : bus.lsu_data;

    always_comb begin
        wait_cnt_d = 4'd0;
        if (bus.alu_valid && !alu_grant) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end

        wr_en_d    = xfer && (sel_index != 5'd0);
        wr_index_d = xfer ? sel_index : wr_index_q;
        wr_data_d  = xfer ? sel_data  : wr_data_q;

        // Clear first so a same-cycle reservation of the same register survives.
        pending_d = pending_q;
        if (xfer) begin
            pending_d[sel_index] = 1'b0;
        end
        if (bus.mark_en && (bus.mark_index != 5'd0)) begin
            pending_d[bus.mark_index] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
            wr_en_q    <= 1'b0;
            wr_index_q <= 5'd0;
            wr_data_q  <= 32'd0;
            pending_q  <= 32'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_index_q <= wr_index_d;
            wr_data_q  <= wr_data_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.alu_ready = alu_grant;
    assign bus.lsu_ready = lsu_grant;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_index  = wr_index_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.pending   = pending_q;

    // The in-flight term keeps a source busy during the cycle its write lands.
    assign bus.chk_busy1 = (bus.chk_index1 != 5'd0) &&
                           (pending_q[bus.chk_index1] || (wr_en_q && (wr_index_q == bus.chk_index1)));
    assign bus.chk_busy2 = (bus.chk_index2 != 5'd0) &&
                           (pending_q[bus.chk_index2] || (wr_en_q && (wr_index_q == bus.chk_index2)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reference model of grants,
// scoreboard and write port, with an expected queue for the write stage.
module tb_regfile_wb_arbiter;
    localparam int MAX_WAIT = 3;

    logic clk = 1'b0;
    logic reset;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [37:0] exp_q[$];

    int          m_wait;
    logic [31:0] m_pending;
    logic        m_wr_en;
    logic [4:0]  m_wr_index;
    logic [31:0] m_wr_data;
    logic        g_alu, g_lsu;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic busy_of(input logic [4:0] ci);
        return (ci != 5'd0) && (m_pending[ci] || (m_wr_en && (m_wr_index == ci)));
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic [4:0]  idx;
        logic [31:0] dat;
        logic        xfer;
        logic [37:0] e;
        #1;
        g_alu = !reset && bus.alu_valid && ((m_wait == MAX_WAIT) || !bus.lsu_valid);
        g_lsu = !reset && bus.lsu_valid && !g_alu;
        check("alu_ready", bus.alu_ready, g_alu);
        check("lsu_ready", bus.lsu_ready, g_lsu);
        check("chk_busy1", bus.chk_busy1, busy_of(bus.chk_index1));
        check("chk_busy2", bus.chk_busy2, busy_of(bus.chk_index2));
        xfer = g_alu | g_lsu;
        idx  = g_alu ? bus.alu_index : bus.lsu_index;
        dat  = g_alu ? bus.alu_data  : bus.lsu_data;
        if (reset)     e = '0;
        else if (xfer) e = {(idx != 5'd0), idx, dat};
        else           e = {1'b0, m_wr_index, m_wr_data};
        exp_q.push_back(e);
        if (reset) begin
            m_wait    = 0;
            m_pending = '0;
        end else begin
            if (bus.alu_valid && !g_alu) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else                         m_wait = 0;
            if (xfer) m_pending[idx] = 1'b0;
            if (bus.mark_en && bus.mark_index != 5'd0) m_pending[bus.mark_index] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("exp_queue_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("wr_en",    bus.wr_en,    e[37]);
            check("wr_index", bus.wr_index, e[36:32]);
            check("wr_data",  bus.wr_data,  e[31:0]);
            check("pending",  bus.pending,  m_pending);
            {m_wr_en, m_wr_index, m_wr_data} = e;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        bus.mark_en   = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.alu_valid  = 1'b1;
        bus.alu_index  = 5'd3;
        bus.alu_data   = 32'h1111_1111;
        bus.lsu_valid  = 1'b1;
        bus.lsu_index  = 5'd4;
        bus.lsu_data   = 32'h2222_2222;
        bus.mark_en    = 1'b1;
        bus.mark_index = 5'd6;
        bus.chk_index1 = 5'd6;
        bus.chk_index2 = 5'd0;
        @(posedge clk);
        @(negedge clk);
        m_wait = 0; m_pending = '0; m_wr_en = 1'b0; m_wr_index = '0; m_wr_data = '0;
        g_alu = 1'b0; g_lsu = 1'b0;

        // Reset held with requests and a mark present: all ignored.
        step();
        step();
        reset = 1'b0;
        idle();

        // Single ALU write to x5.
        bus.alu_valid = 1'b1; bus.alu_index = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        #1 check("alu_single_ready", bus.alu_ready, 1'b1);
        step();
        idle();
        check("alu_single_wr_en", bus.wr_en, 1'b1);
        check("alu_single_wr_data", bus.wr_data, 32'hDEAD_BEEF);
        step();
        check("alu_single_wr_en_after", bus.wr_en, 1'b0);

        // Both continuously valid: LSU, LSU, LSU, ALU, repeating.
        bus.alu_valid = 1'b1; bus.alu_index = 5'd10; bus.alu_data = 32'hA000_0000;
        bus.lsu_valid = 1'b1; bus.lsu_index = 5'd20; bus.lsu_data = 32'hB000_0000;
        for (int i = 0; i < 12; i++) begin
            #1 check("grant_order_alu", bus.alu_ready, (i % 4) == 3);
            step();
            if (g_alu) begin bus.alu_index = 5'(10 + i); bus.alu_data = 32'hA000_0000 + i; end
            if (g_lsu) begin bus.lsu_index = 5'(20 + i % 8); bus.lsu_data = 32'hB000_0000 + i; end
        end
        idle();
        step();

        // Mark x7, LSU writes it at cycle 3; busy through cycle 4, clear at 5.
        bus.chk_index1 = 5'd7;
        bus.mark_en = 1'b1; bus.mark_index = 5'd7;
        step();
        bus.mark_en = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) begin bus.lsu_valid = 1'b1; bus.lsu_index = 5'd7; bus.lsu_data = 32'h0000_0777; end
            else bus.lsu_valid = 1'b0;
            #1 check("x7_busy", bus.chk_busy1, c <= 4);
            if (c == 4) check("x7_pending", bus.pending[7], 1'b0);
            step();
        end
        idle();

        // Same-cycle mark and write of x9: reservation survives.
        bus.mark_en = 1'b1; bus.mark_index = 5'd9;
        step();
        bus.alu_valid = 1'b1; bus.alu_index = 5'd9; bus.alu_data = 32'h9999_9999;
        step();
        idle();
        check("x9_still_pending", bus.pending[9], 1'b1);
        bus.mark_en = 1'b1; bus.mark_index = 5'd0; bus.chk_index2 = 5'd0;
        step();
        bus.mark_en = 1'b0;
        check("x0_pending", bus.pending[0], 1'b0);
        #1 check("x0_busy", bus.chk_busy2, 1'b0);
        step();

        // Write to x0 is consumed but suppressed.
        bus.alu_valid = 1'b1; bus.alu_index = 5'd0; bus.alu_data = 32'h0000_1234;
        #1 check("x0_write_ready", bus.alu_ready, 1'b1);
        step();
        idle();
        check("x0_write_wr_en", bus.wr_en, 1'b0);
        step();

        // Transfer at N then reset at N+1 drops the queued write.
        bus.mark_en = 1'b1; bus.mark_index = 5'd12;
        step();
        bus.mark_en = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_index = 5'd12; bus.alu_data = 32'hC0DE_0012;
        step();
        reset = 1'b1;
        bus.lsu_valid = 1'b1; bus.lsu_index = 5'd13;
        step();
        check("reset_drop_wr_en", bus.wr_en, 1'b0);
        check("reset_pending", bus.pending, 32'd0);
        reset = 1'b0;
        idle();

        // Random traffic, refused requesters hold their request.
        for (int i = 0; i < 80; i++) begin
            if (!bus.alu_valid || g_alu) begin
                bus.alu_valid = 1'($urandom_range(0, 1));
                bus.alu_index = 5'($urandom_range(0, 31));
                bus.alu_data  = $urandom;
            end
            if (!bus.lsu_valid || g_lsu) begin
                bus.lsu_valid = 1'($urandom_range(0, 1));
                bus.lsu_index = 5'($urandom_range(0, 31));
                bus.lsu_data  = $urandom;
            end
            bus.mark_en    = 1'($urandom_range(0, 1));
            bus.mark_index = 5'($urandom_range(0, 31));
            bus.chk_index1 = 5'($urandom_range(0, 31));
            bus.chk_index2 = 5'($urandom_range(0, 31));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
